// File: rtl/xulie_gen_if.sv
// Control and serial-output bundle of the test-pattern transmitter.
// The master drives the transmit request; the slave is the transmitter itself.
interface xulie_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [7:0]       repeat_cnt;
    logic [7:0]       gap_len;
    logic             fill_rand;

    logic             data_out;
    logic             bit_stb;
    logic             pat_end;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, pat_len, repeat_cnt, gap_len, fill_rand,
        input  data_out, bit_stb, pat_end, busy, done
    );

    modport slave (
        input  start, pattern, pat_len, repeat_cnt, gap_len, fill_rand,
        output data_out, bit_stb, pat_end, busy, done
    );
endinterface

// File: rtl/xulie_gen.sv
// Serial test-pattern transmitter: filler run then pattern MSB-first, repeated N times.
// First bit appears the cycle after start is accepted; no backpressure, start only taken in IDLE.
module xulie_gen #(
    parameter int          PAT_W     = 8,
    parameter int          LEN_W     = 4,
    parameter int          CLK_DIV   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    xulie_gen_if.slave bus
);
    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SEND,
        S_DONE
    } state_e;

    state_e           state_q,   state_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [PAT_W-1:0] sh_q,      sh_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] idx_q,     idx_d;
    logic [7:0]       rep_q,     rep_d;
    logic [7:0]       gap_len_q, gap_len_d;
    logic [7:0]       gap_q,     gap_d;
    logic             fill_q,    fill_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [15:0]      lfsr_q,    lfsr_d;

    logic [LEN_W-1:0] len_in;
    logic [PAT_W-1:0] pat_in;
    logic [15:0]      lfsr_nxt;
    logic             bit_first;
    logic             bit_last;

    logic             data_out_w;
    logic             bit_stb_w;
    logic             pat_end_w;
    logic             busy_w;
    logic             done_w;

    // Pattern is stored left-aligned so the serializer always shifts out the MSB.
    always_comb begin
        len_in = bus.pat_len;
        if (bus.pat_len == '0 || bus.pat_len > LEN_MAX) begin
            len_in = LEN_MAX;
        end
        pat_in = bus.pattern << (PAT_W - int'(len_in));
    end

    assign lfsr_nxt  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign bit_first = (div_q == DIV_LAST);
    assign bit_last  = (div_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_q     <= '0;
            fill_q    <= 1'b0;
            div_q     <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_q     <= gap_d;
            fill_q    <= fill_d;
            div_q     <= div_d;
            lfsr_q    <= lfsr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_d     = gap_q;
        fill_d    = fill_q;
        div_d     = div_q;
        lfsr_d    = lfsr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pat_d     = pat_in;
                    sh_d      = pat_in;
                    len_d     = len_in;
                    idx_d     = len_in - LEN_W'(1);
                    rep_d     = (bus.repeat_cnt == 8'd0) ? 8'd0 : bus.repeat_cnt - 8'd1;
                    gap_len_d = bus.gap_len;
                    fill_d    = bus.fill_rand;
                    div_d     = DIV_LAST;
                    if (bus.gap_len != 8'd0) begin
                        gap_d   = bus.gap_len - 8'd1;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end

            S_GAP: begin
                if (bit_last) begin
                    div_d = DIV_LAST;
                    if (fill_q) begin
                        lfsr_d = lfsr_nxt;
                    end
                    if (gap_q == 8'd0) begin
                        state_d = S_SEND;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            S_SEND: begin
                if (bit_last) begin
                    div_d = DIV_LAST;
                    if (idx_q == '0) begin
                        if (rep_q == 8'd0) begin
                            state_d = S_DONE;
                        end else begin
                            // Next repetition restarts from the stored, aligned pattern.
                            rep_d = rep_q - 8'd1;
                            sh_d  = pat_q;
                            idx_d = len_q - LEN_W'(1);
                            if (gap_len_q != 8'd0) begin
                                gap_d   = gap_len_q - 8'd1;
                                state_d = S_GAP;
                            end else begin
                                state_d = S_SEND;
                            end
                        end
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                        sh_d  = sh_q << 1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_w     = (state_q == S_GAP) || (state_q == S_SEND);
        done_w     = (state_q == S_DONE);
        bit_stb_w  = busy_w && bit_first;
        pat_end_w  = (state_q == S_SEND) && bit_first && (idx_q == '0);
        data_out_w = 1'b0;
        if (state_q == S_GAP) begin
            data_out_w = fill_q & lfsr_q[0];
        end else if (state_q == S_SEND) begin
            data_out_w = sh_q[PAT_W-1];
        end
    end

    assign bus.data_out = data_out_w;
    assign bus.bit_stb  = bit_stb_w;
    assign bus.pat_end  = pat_end_w;
    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
endmodule

// File: tb/tb_xulie_gen.sv
// Scoreboard bench for xulie_gen: stimulus queues expected bits, monitors pop on bit_stb.
module tb_xulie_gen;
    typedef struct {
        int unsigned cyc;
        bit          d;
        bit          pe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    xulie_gen_if #(.PAT_W(8), .LEN_W(4)) a_if ();
    xulie_gen_if #(.PAT_W(8), .LEN_W(4)) b_if ();

    xulie_gen #(.PAT_W(8), .LEN_W(4), .CLK_DIV(1), .LFSR_SEED(16'hACE1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    xulie_gen #(.PAT_W(8), .LEN_W(4), .CLK_DIV(3), .LFSR_SEED(16'hACE1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int checks   = 0;
    int failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    int done_a = 0, done_b = 0, pe_a = 0, pe_b = 0;
    int busy_a = 0, busy_b = 0, bits_a = 0, bits_b = 0;
    int unsigned done_a_cyc = 0, done_b_cyc = 0;
    bit prev_b = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Expected bit stream: n bits of 'bits' MSB-first, one every 'stride' cycles.
    task automatic push_pat(input bit w, input int unsigned cstart, input int stride,
                            input logic [31:0] bits, input int n, input bit mark_end);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc = cstart + i * stride;
            e.d   = bits[n-1-i];
            e.pe  = mark_end && (i == n - 1);
            if (w) qb.push_back(e);
            else   qa.push_back(e);
        end
    endtask

    task automatic push_lfsr(input int unsigned cstart, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc  = cstart + i;
            e.d    = lfsr_m[0];
            e.pe   = 1'b0;
            qa.push_back(e);
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end
    endtask

    task automatic go(input bit w, input logic [7:0] p, input logic [3:0] l, input logic [7:0] r,
                      input logic [7:0] g, input bit f, output int unsigned c0);
        @(negedge clk);
        if (w) begin
            b_if.pattern = p; b_if.pat_len = l; b_if.repeat_cnt = r;
            b_if.gap_len = g; b_if.fill_rand = f; b_if.start = 1'b1;
        end else begin
            a_if.pattern = p; a_if.pat_len = l; a_if.repeat_cnt = r;
            a_if.gap_len = g; a_if.fill_rand = f; a_if.start = 1'b1;
        end
        c0 = cyc;
    endtask

    task automatic release_start();
        @(negedge clk);
        a_if.start = 1'b0;
        b_if.start = 1'b0;
    endtask

    task automatic wait_done(input bit w, input int prev);
        int n = 0;
        while (((w ? done_b : done_a) == prev) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_if.busy)    busy_a++;
        if (a_if.pat_end) pe_a++;
        if (a_if.done) begin
            done_a++;
            done_a_cyc = cyc;
        end
        if (a_if.bit_stb) begin
            bits_a++;
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL A_extra_bit cyc=%0d data_out=%0b required=no bit", cyc, a_if.data_out);
            end else begin
                e = qa.pop_front();
                chk("A_bit_cycle", cyc, e.cyc);
                chk("A_data_out", a_if.data_out, e.d);
                chk("A_pat_end", a_if.pat_end, e.pe);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_if.busy)    busy_b++;
        if (b_if.pat_end) pe_b++;
        if (b_if.done) begin
            done_b++;
            done_b_cyc = cyc;
        end
        if (b_if.busy && !b_if.bit_stb) chk("B_hold", b_if.data_out, prev_b);
        if (b_if.bit_stb) begin
            bits_b++;
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL B_extra_bit cyc=%0d data_out=%0b required=no bit", cyc, b_if.data_out);
            end else begin
                e = qb.pop_front();
                chk("B_bit_cycle", cyc, e.cyc);
                chk("B_data_out", b_if.data_out, e.d);
                chk("B_pat_end", b_if.pat_end, e.pe);
            end
        end
        prev_b = b_if.data_out;
    end

    initial begin
        #300us;
        $display("FAIL watchdog cyc=%0d required=run complete", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c0;
        int d0, p0, b0, n0;

        a_if.start = 1'b0; a_if.pattern = '0; a_if.pat_len = '0;
        a_if.repeat_cnt = '0; a_if.gap_len = '0; a_if.fill_rand = 1'b0;
        b_if.start = 1'b0; b_if.pattern = '0; b_if.pat_len = '0;
        b_if.repeat_cnt = '0; b_if.gap_len = '0; b_if.fill_rand = 1'b0;

        repeat (3) @(negedge clk);
        chk("A_reset_outputs", {a_if.data_out, a_if.bit_stb, a_if.pat_end, a_if.busy, a_if.done}, 0);
        chk("B_reset_outputs", {b_if.data_out, b_if.bit_stb, b_if.pat_end, b_if.busy, b_if.done}, 0);
        rst = 1'b0;

        // Random filler straight after reset: 16 LFSR bits then 8'hB2.
        d0 = done_a; b0 = busy_a;
        go(0, 8'hB2, 4'd8, 8'd1, 8'd16, 1'b1, c0);
        push_lfsr(c0 + 1, 16);
        push_pat(0, c0 + 17, 1, 32'hB2, 8, 1'b1);
        release_start();
        wait_done(0, d0);
        chk("rand_done_count", done_a - d0, 1);
        chk("rand_done_cycle", done_a_cyc - c0, 25);
        chk("rand_busy_cycles", busy_a - b0, 24);
        chk("rand_queue_left", qa.size(), 0);

        // LFSR continues from where the previous run left it.
        d0 = done_a;
        go(0, 8'h03, 4'd2, 8'd1, 8'd4, 1'b1, c0);
        push_lfsr(c0 + 1, 4);
        push_pat(0, c0 + 5, 1, 32'h3, 2, 1'b1);
        release_start();
        wait_done(0, d0);
        chk("rand2_done_cycle", done_a_cyc - c0, 7);
        chk("rand2_queue_left", qa.size(), 0);

        // Basic: 000 B2 000 B2.
        d0 = done_a; b0 = busy_a; p0 = pe_a;
        go(0, 8'hB2, 4'd8, 8'd2, 8'd3, 1'b0, c0);
        push_pat(0, c0 + 1, 1, 32'h0, 3, 1'b0);
        push_pat(0, c0 + 4, 1, 32'hB2, 8, 1'b1);
        push_pat(0, c0 + 12, 1, 32'h0, 3, 1'b0);
        push_pat(0, c0 + 15, 1, 32'hB2, 8, 1'b1);
        release_start();
        wait_done(0, d0);
        chk("basic_done_count", done_a - d0, 1);
        chk("basic_done_cycle", done_a_cyc - c0, 23);
        chk("basic_busy_cycles", busy_a - b0, 22);
        chk("basic_pat_end_count", pe_a - p0, 2);
        chk("basic_queue_left", qa.size(), 0);

        // Slow bit rate on the CLK_DIV=3 instance.
        d0 = done_b; b0 = busy_b; p0 = pe_b; n0 = bits_b;
        go(1, 8'h0D, 4'd4, 8'd1, 8'd0, 1'b0, c0);
        push_pat(1, c0 + 1, 3, 32'hD, 4, 1'b1);
        release_start();
        wait_done(1, d0);
        chk("slow_done_cycle", done_b_cyc - c0, 13);
        chk("slow_busy_cycles", busy_b - b0, 12);
        chk("slow_pat_end_count", pe_b - p0, 1);
        chk("slow_bit_count", bits_b - n0, 4);
        chk("slow_queue_left", qb.size(), 0);

        // Clamping: pat_len=0 -> 8 bits, repeat_cnt=0 -> once.
        d0 = done_a; p0 = pe_a; n0 = bits_a;
        go(0, 8'h5A, 4'd0, 8'd0, 8'd0, 1'b0, c0);
        push_pat(0, c0 + 1, 1, 32'h5A, 8, 1'b1);
        release_start();
        wait_done(0, d0);
        chk("clamp_done_cycle", done_a_cyc - c0, 9);
        chk("clamp_pat_end_count", pe_a - p0, 1);
        chk("clamp_bit_count", bits_a - n0, 8);

        // Start pulses during SEND (cycle 5) and during DONE (cycle 11) are ignored.
        d0 = done_a; n0 = bits_a;
        go(0, 8'hC3, 4'd8, 8'd1, 8'd2, 1'b0, c0);
        push_pat(0, c0 + 1, 1, 32'h0, 2, 1'b0);
        push_pat(0, c0 + 3, 1, 32'hC3, 8, 1'b1);
        release_start();
        repeat (4) @(negedge clk);
        a_if.pattern = 8'hFF; a_if.gap_len = 8'd0; a_if.repeat_cnt = 8'd5; a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (5) @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("busy_start_done_count", done_a - d0, 1);
        chk("busy_start_done_cycle", done_a_cyc - c0, 11);
        chk("busy_start_bit_count", bits_a - n0, 10);
        chk("busy_start_idle_after", a_if.busy, 0);

        // Reset asserted in cycle 6 of the basic run aborts it without done.
        d0 = done_a;
        go(0, 8'hB2, 4'd8, 8'd2, 8'd3, 1'b0, c0);
        push_pat(0, c0 + 1, 1, 32'h0, 3, 1'b0);
        push_pat(0, c0 + 4, 1, 32'h5, 3, 1'b0);
        release_start();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {a_if.data_out, a_if.bit_stb, a_if.pat_end, a_if.busy, a_if.done}, 0);
        rst = 1'b0;
        lfsr_m = 16'hACE1;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done", done_a - d0, 0);
        chk("abort_queue_left", qa.size(), 0);

        d0 = done_a;
        go(0, 8'hB2, 4'd8, 8'd2, 8'd3, 1'b0, c0);
        push_pat(0, c0 + 1, 1, 32'h0, 3, 1'b0);
        push_pat(0, c0 + 4, 1, 32'hB2, 8, 1'b1);
        push_pat(0, c0 + 12, 1, 32'h0, 3, 1'b0);
        push_pat(0, c0 + 15, 1, 32'hB2, 8, 1'b1);
        release_start();
        wait_done(0, d0);
        chk("rerun_done_cycle", done_a_cyc - c0, 23);
        chk("rerun_queue_left", qa.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xulie_gen.md
Name: xulie_gen

Overview:
- Serial test-pattern transmitter; the sending-end counterpart of the serial sequence detector.
- Emits a programmable bit pattern MSB-first on a 1-bit serial line, repeated N times.
- Each repetition is preceded by a run of filler bits, either zeros or pseudo-random.
- Drives the detector's data_in in benches and on-board demos.
- Raises a marker pulse on every completed pattern so a scoreboard can check the detector's find_ok.

Parameters:
- PAT_W, 8, maximum pattern width in bits.
- LEN_W, 4, width of pat_len; must satisfy 2^LEN_W > PAT_W.
- CLK_DIV, 1, clock cycles each serial bit is held (>=1).
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a transmission; sampled only in IDLE.
- pattern  input  PAT_W  pattern bits; bit pat_len-1 is sent first.
- pat_len  input  LEN_W  pattern length 1..PAT_W; 0 or >PAT_W is treated as PAT_W.
- repeat_cnt  input  8  number of pattern repetitions; 0 is treated as 1.
- gap_len  input  8  filler bits before each repetition; 0 means no filler.
- fill_rand  input  1  1: filler bit = lfsr[0]; 0: filler bit = 0.
- data_out  output  1  serial bit stream.
- bit_stb  output  1  high on the first clock of each new bit.
- pat_end  output  1  high with bit_stb of the last bit of each repetition.
- busy  output  1  high while transmitting.
- done  output  1  one-cycle pulse when a transmission completes.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE, LFSR=LFSR_SEED.
  - data_out, bit_stb, pat_end, busy, done all 0.
  - Reset mid-transmission aborts immediately; no done pulse.
- States: IDLE, GAP, SEND, DONE.
- IDLE:
  - data_out=0.
  - On start=1, latch pattern, pat_len (after clamp), repeat_cnt (after clamp), gap_len and fill_rand.
  - Next cycle: enter GAP if gap_len!=0, else SEND.
- Start acceptance:
  - start is ignored in GAP/SEND/DONE.
  - Changing inputs while busy has no effect.
- Bit timing:
  - Each bit occupies exactly CLK_DIV cycles.
  - bit_stb=1 on the first of those cycles only.
  - The first bit appears on the cycle after start is accepted (latency 1).
  - busy=1 from that cycle through the last cycle of the last bit.
- GAP:
  - Emits gap_len filler bits, then goes to SEND.
  - With fill_rand=1 the LFSR advances once per filler bit, at the end of that bit's CLK_DIV period.
  - LFSR is Fibonacci, taps x^16+x^14+x^13+x^11+1, shift right, new MSB = feedback.
  - The first filler bit after reset equals LFSR_SEED[0].
  - LFSR state persists across transmissions.
- SEND:
  - Emits pattern[pat_len-1] down to pattern[0].
  - pat_end pulses with bit_stb of pattern[0].
  - After the bit period, if repetitions remain, go to GAP (or SEND if gap_len=0); else go to DONE.
- DONE: exactly one cycle with done=1, busy=0, data_out=0; then IDLE.
- Start acceptance after DONE: start is accepted no earlier than the cycle after DONE.
- Counters:
  - Bit index is LEN_W wide.
  - Gap counter and repetition counter are 8 wide.
  - Division counter is $clog2(CLK_DIV+1) wide.
  - No wrap-around: all counters count down to 0 and reload.

Test Plan:
- Basic pattern, zero filler: CLK_DIV=1, pattern=8'hB2, pat_len=8, repeat_cnt=2, gap_len=3, fill_rand=0, start at cycle 0.
  - Expect data_out over cycles 1..22: 000 10110010 000 10110010.
  - bit_stb=1 on cycles 1..22; pat_end at cycles 11 and 22.
  - done at cycle 23; busy high for cycles 1..22.
- Short pattern, slow bit rate: pattern=8'h0D, pat_len=4, gap_len=0, repeat_cnt=1, CLK_DIV=3.
  - Expect 1,1,0,1 with each bit held 3 cycles (cycles 1..12).
  - bit_stb on cycles 1,4,7,10; pat_end at 10; done at 13.
- Length/repeat clamping: pat_len=0 and repeat_cnt=0 -> exactly 8 pattern bits sent once, one pat_end pulse.
- Random filler: fill_rand=1, gap_len=16, first run after reset -> filler bits match a software model of the LFSR from 16'hACE1; first filler bit=1.
- Start while busy: start pulsed during SEND and during DONE -> ignored; total bit count unchanged; only one done pulse.
- Reset mid-run: rst=1 at cycle 6 of the first scenario -> next cycle all outputs 0, no done; a new start afterwards runs cleanly.
- Loopback: connect to the sequence detector with its target pattern -> find_ok asserts within the detector's latency after each pat_end.
